mem_rsp_fifo: RTL and testbench

- Downstream consumer of the 16x32 memory block's read-response pair (o_data_out/o_valid).
- Buffers each valid memory response in a small first-word-fall-through FIFO.
- Re-presents the buffered words to the next stage with a valid/ready handshake, so the consumer can stall without losing data.
- Maintains running statistics: accepted-word count, 32-bit additive checksum, and a sticky overflow flag for dropped responses.

---
 rtl/mem_rsp_fifo.sv | 121 ++++++++++++
 tb/tb_mem_rsp_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_rsp_fifo.sv
// mem_rsp_fifo: first-word-fall-through buffer for memory read responses,
// re-presented with a valid/ready handshake, plus running statistics
// (accepted-word count, additive checksum, sticky overflow).
module mem_rsp_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [DATA_W-1:0]        i_data,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_data,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow,
  output logic [CNT_W-1:0]         o_word_cnt,
  output logic [DATA_W-1:0]        o_checksum,
  input  logic                     i_clr_stats
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [DATA_W-1:0] csum_q, csum_d;

  logic push, pop, drop;

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign pop  = valid_q & i_ready;
  assign push = i_valid & (~full_q | pop);
  assign drop = i_valid & full_q & ~pop;

  // Next-state: pointers, occupancy, flags and statistics.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    wcnt_d   = wcnt_q;
    csum_d   = csum_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == OCC_W'(DEPTH));
    empty_d = (count_d == '0);
    valid_d = ~empty_d;

    // Clear first, then let this cycle's events land on top of it.
    if (i_clr_stats) begin
      ovf_d  = 1'b0;
      wcnt_d = '0;
      csum_d = '0;
    end
    if (push) begin
      csum_d = csum_d + i_data;
      if (wcnt_d != {CNT_W{1'b1}}) wcnt_d = wcnt_d + CNT_W'(1);
    end
    if (drop) ovf_d = 1'b1;
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      wcnt_q   <= '0;
      csum_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      wcnt_q   <= wcnt_d;
      csum_q   <= csum_d;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_valid    = valid_q;
  assign o_data     = empty_q ? '0 : mem_q[rd_ptr_q];
  assign o_count    = count_q;
  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_overflow = ovf_q;
  assign o_word_cnt = wcnt_q;
  assign o_checksum = csum_q;

endmodule

// File: tb/tb_mem_rsp_fifo.sv
// Scoreboard bench for mem_rsp_fifo: stimulus feeds a queue-based reference
// model; a negedge monitor checks flags/statistics and pops expected words.
module tb_mem_rsp_fifo;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 4;   // small so saturation is reachable
  localparam int unsigned SAT    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_valid = 1'b0;
  logic [DATA_W-1:0] i_data = '0;
  logic              i_ready = 1'b0;
  logic              i_clr_stats = 1'b0;
  logic              o_valid, o_full, o_empty, o_overflow;
  logic [DATA_W-1:0] o_data, o_checksum;
  logic [$clog2(DEPTH):0] o_count;
  logic [CNT_W-1:0]  o_word_cnt;

  mem_rsp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
    .o_overflow(o_overflow), .o_word_cnt(o_word_cnt),
    .o_checksum(o_checksum), .i_clr_stats(i_clr_stats)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit armed   = 1'b0;

  // Reference model state
  logic [DATA_W-1:0] exp_q[$];
  int unsigned       m_cnt  = 0;
  int unsigned       m_wc   = 0;
  logic [DATA_W-1:0] m_cs   = '0;
  bit                m_ovf  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; model updated after the edge.
  task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit c);
    bit pop_m, push_m, drop_m;
    i_valid = v; i_data = d; i_ready = r; i_clr_stats = c;
    pop_m  = (m_cnt > 0) && r;
    push_m = v && ((m_cnt < DEPTH) || pop_m);
    drop_m = v && (m_cnt == DEPTH) && !pop_m;
    @(posedge clk); #1;
    if (push_m) exp_q.push_back(d);
    m_cnt = m_cnt + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
    if (c) begin m_wc = 0; m_cs = '0; m_ovf = 1'b0; end
    if (push_m) begin
      m_cs = m_cs + d;
      if (m_wc < SAT) m_wc++;
    end
    if (drop_m) m_ovf = 1'b1;
    i_valid = 1'b0; i_ready = 1'b0; i_clr_stats = 1'b0;
  endtask

  task automatic do_reset(input int n);
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_clr_stats = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    i_rst = 1'b0;
    exp_q.delete();
    m_cnt = 0; m_wc = 0; m_cs = '0; m_ovf = 1'b0;
  endtask

  // Monitor: per-cycle flag/stat checks and in-order head-word scoreboard.
  always @(negedge clk) begin
    if (armed && !i_rst) begin
      chk("count", 64'(o_count), 64'(m_cnt));
      chk("valid", 64'(o_valid), 64'(m_cnt != 0));
      chk("empty", 64'(o_empty), 64'(m_cnt == 0));
      chk("full", 64'(o_full), 64'(m_cnt == DEPTH));
      chk("word_cnt", 64'(o_word_cnt), 64'(m_wc));
      chk("checksum", 64'(o_checksum), 64'(m_cs));
      chk("overflow", 64'(o_overflow), 64'(m_ovf));
      if (m_cnt == 0) chk("data_when_empty", 64'(o_data), 64'd0);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) chk("pop_without_expected", 64'd1, 64'd0);
        else chk("head_word", 64'(o_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset then idle
    do_reset(2);
    armed = 1'b1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_empty", 64'(o_empty), 64'd1);
    chk("rst_data", 64'(o_data), 64'd0);
    step(0, '0, 0, 0);

    // Basic flow
    step(1, 32'h1111_1111, 1, 0);
    chk("basic_head1", 64'(o_data), 64'h1111_1111);
    step(1, 32'h2222_2222, 1, 0);
    chk("basic_head2", 64'(o_data), 64'h2222_2222);
    step(0, '0, 1, 0);
    chk("basic_wc", 64'(o_word_cnt), 64'd2);
    chk("basic_cs", 64'(o_checksum), 64'h3333_3333);

    // Fill and overflow
    step(0, '0, 0, 1);
    for (int i = 1; i <= 5; i++) step(1, DATA_W'(32'hA000_0000 + i), 0, 0);
    chk("ovf_full", 64'(o_full), 64'd1);
    chk("ovf_flag", 64'(o_overflow), 64'd1);
    chk("ovf_wc", 64'(o_word_cnt), 64'd4);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    chk("drain_empty", 64'(o_empty), 64'd1);

    // Full with simultaneous push and pop across pointer wrap
    step(0, '0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, DATA_W'(32'hB000_0000 + i), 0, 0);
    for (int i = 0; i < 3; i++) step(1, DATA_W'(32'hC000_0000 + i), 1, 0);
    chk("pp_count", 64'(o_count), 64'd4);
    chk("pp_ovf", 64'(o_overflow), 64'd0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);

    // Checksum wrap and clear with push
    step(0, '0, 0, 1);
    step(1, 32'hFFFF_FFFF, 1, 0);
    step(1, 32'h0000_0002, 1, 0);
    chk("wrap_cs", 64'(o_checksum), 64'h1);
    step(1, 32'h5, 1, 1);
    chk("clr_cs", 64'(o_checksum), 64'h5);
    chk("clr_wc", 64'(o_word_cnt), 64'd1);
    chk("clr_ovf", 64'(o_overflow), 64'd0);

    // Clear concurrent with an overflow: set wins
    step(0, '0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, DATA_W'(i), 0, 0);
    step(1, 32'hDEAD_BEEF, 0, 1);
    chk("clr_vs_ovf", 64'(o_overflow), 64'd1);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);

    // Word counter saturation
    step(0, '0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, DATA_W'(i), 1, 0);
    chk("sat_wc", 64'(o_word_cnt), 64'(SAT));
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) step(1, DATA_W'(32'hE000_0000 + i), 0, 0);
    do_reset(1);
    chk("mrst_count", 64'(o_count), 64'd0);
    chk("mrst_valid", 64'(o_valid), 64'd0);
    step(1, 32'hA5A5_A5A5, 0, 0);
    chk("mrst_head_valid", 64'(o_valid), 64'd1);
    chk("mrst_head", 64'(o_data), 64'hA5A5_A5A5);
    step(0, '0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset(1);
      else step($urandom_range(0, 99) < 60, $urandom(),
                $urandom_range(0, 99) < 50, $urandom_range(0, 49) == 0);
    end
    for (int i = 0; i < DEPTH + 1; i++) step(0, '0, 1, 0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
